// File: rtl/circle_pkg.sv
// Shared types and constants for the midpoint circle rasteriser and its
// octant point generator.
package circle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PLOT,
        UPDATE,
        DONE
    } state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int COORD_W = 10;
    localparam int CRIT_W  = 11;
    localparam int OCT_W   = 3;

    localparam logic [OCT_W-1:0] OCT_0 = 3'd0;
    localparam logic [OCT_W-1:0] OCT_1 = 3'd1;
    localparam logic [OCT_W-1:0] OCT_2 = 3'd2;
    localparam logic [OCT_W-1:0] OCT_3 = 3'd3;
    localparam logic [OCT_W-1:0] OCT_4 = 3'd4;
    localparam logic [OCT_W-1:0] OCT_5 = 3'd5;
    localparam logic [OCT_W-1:0] OCT_6 = 3'd6;
    localparam logic [OCT_W-1:0] OCT_7 = 3'd7;

    localparam logic [OCT_W-1:0] OCT_FIRST = OCT_0;
    localparam logic [OCT_W-1:0] OCT_LAST  = OCT_7;

endpackage

// File: rtl/circle_octant.sv
// Maps one first-octant offset (ox, oy) onto one of the eight symmetric
// points around a centre and reports whether that point lands on screen.
module circle_octant
    import circle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic signed [COORD_W-1:0] cx,
    input  logic signed [COORD_W-1:0] cy,
    input  logic signed [COORD_W-1:0] ox,
    input  logic signed [COORD_W-1:0] oy,
    input  logic        [OCT_W-1:0]   oct,
    output logic signed [COORD_W-1:0] px,
    output logic signed [COORD_W-1:0] py,
    output logic                      on_screen
);

    localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
    localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        px = cx + oy;
        py = cy - ox;
        case (oct)
            OCT_0: begin px = cx + ox; py = cy + oy; end
            OCT_1: begin px = cx + oy; py = cy + ox; end
            OCT_2: begin px = cx - ox; py = cy + oy; end
            OCT_3: begin px = cx - oy; py = cy + ox; end
            OCT_4: begin px = cx - ox; py = cy - oy; end
            OCT_5: begin px = cx - oy; py = cy - ox; end
            OCT_6: begin px = cx + ox; py = cy - oy; end
            default: ;
        endcase
    end

    // Sign bit set means the point is left of / above the frame.
    assign on_screen = !px[COORD_W-1] && (px < X_LIM) &&
                       !py[COORD_W-1] && (py < Y_LIM);

endmodule

// File: rtl/circle.sv
// Midpoint circle rasteriser: one candidate outline pixel per cycle into the
// VGA adapter, off-screen pixels suppressed, start/done handshake.
module circle
    import circle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       colour,
    input  logic [X_W-1:0]   centre_x,
    input  logic [Y_W-1:0]   centre_y,
    input  logic [7:0]       radius,
    input  logic             start,
    output logic             done,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [2:0]       vga_colour,
    output logic             vga_plot
);

    state_t                    state_q, state_d;
    logic [OCT_W-1:0]          oct_q, oct_d;
    logic signed [COORD_W-1:0] ox_q, ox_d;
    logic signed [COORD_W-1:0] oy_q, oy_d;
    logic signed [CRIT_W-1:0]  crit_q, crit_d;
    logic [2:0]                colour_q, colour_d;
    logic [X_W-1:0]            cx_q, cx_d;
    logic [Y_W-1:0]            cy_q, cy_d;

    logic signed [COORD_W-1:0] oy_inc, ox_dec, ox_nxt, step;
    logic                      crit_le0, more;
    logic signed [COORD_W-1:0] px, py;
    logic                      on_screen;

    // ox is signed so radius 0 steps to -1 and terminates after one pass.
    assign oy_inc   = oy_q + COORD_W'(1);
    assign ox_dec   = ox_q - COORD_W'(1);
    assign crit_le0 = crit_q[CRIT_W-1] || (crit_q == '0);
    assign ox_nxt   = crit_le0 ? ox_q : ox_dec;
    assign step     = crit_le0 ? oy_inc : oy_inc - ox_dec;
    assign more     = (oy_inc <= ox_nxt);

    always_comb begin
        state_d  = state_q;
        oct_d    = oct_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        crit_d   = crit_q;
        colour_d = colour_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        unique case (state_q)
            IDLE: if (start) state_d = INIT;
            INIT: begin
                colour_d = colour;
                cx_d     = centre_x;
                cy_d     = centre_y;
                ox_d     = COORD_W'(radius);
                oy_d     = '0;
                crit_d   = CRIT_W'(1) - CRIT_W'(radius);
                oct_d    = OCT_FIRST;
                state_d  = PLOT;
            end
            PLOT: begin
                oct_d = oct_q + OCT_W'(1);
                if (oct_q == OCT_LAST) state_d = UPDATE;
            end
            UPDATE: begin
                // {step, 1} is 2*step + 1 without a separate multiply.
                oy_d    = oy_inc;
                ox_d    = ox_nxt;
                crit_d  = crit_q + {step, 1'b1};
                oct_d   = OCT_FIRST;
                state_d = more ? PLOT : DONE;
            end
            DONE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            oct_q    <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            crit_q   <= '0;
            colour_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
        end else begin
            state_q  <= state_d;
            oct_q    <= oct_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            crit_q   <= crit_d;
            colour_q <= colour_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
        end
    end

    circle_octant #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_octant (
        .cx        (COORD_W'(cx_q)),
        .cy        (COORD_W'(cy_q)),
        .ox        (ox_q),
        .oy        (oy_q),
        .oct       (oct_q),
        .px        (px),
        .py        (py),
        .on_screen (on_screen)
    );

    assign vga_plot   = (state_q == PLOT) && on_screen;
    assign vga_x      = X_W'(vga_plot ? px : '0);
    assign vga_y      = Y_W'(vga_plot ? py : '0);
    assign vga_colour = colour_q;
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_circle.sv
// Directed bench for the circle rasteriser: table of draws checked against
// hand-computed timing and a software midpoint model, plus handshake cases.
module tb_circle;
    import circle_pkg::*;

    localparam int MAX_CYC = 4000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] colour;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic       start;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    circle dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .colour     (colour),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .start      (start),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int plot_cyc[$];
    int plot_xy[$];
    bit dut_set[int];
    bit model_set[int];
    int bad_colour;

    typedef struct {
        int         cx;
        int         cy;
        int         r;
        logic [2:0] col;
        int         exp_done;   // -1: take 2+9N from the model
        int         exp_plots;  // -1: take plot count from the model
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference midpoint algorithm; counts iterations and on-screen plots.
    task automatic model(input int cx, input int cy, input int r,
                         output int n_iter, output int n_plot);
        int ox, oy, crit, px, py;
        model_set.delete();
        n_iter = 0;
        n_plot = 0;
        ox = r;
        oy = 0;
        crit = 1 - r;
        do begin
            n_iter++;
            for (int o = 0; o < 8; o++) begin
                case (o)
                    0: begin px = cx + ox; py = cy + oy; end
                    1: begin px = cx + oy; py = cy + ox; end
                    2: begin px = cx - ox; py = cy + oy; end
                    3: begin px = cx - oy; py = cy + ox; end
                    4: begin px = cx - ox; py = cy - oy; end
                    5: begin px = cx - oy; py = cy - ox; end
                    6: begin px = cx + ox; py = cy - oy; end
                    default: begin px = cx + oy; py = cy - ox; end
                endcase
                if (px >= 0 && px < 160 && py >= 0 && py < 120) begin
                    n_plot++;
                    model_set[px * 256 + py] = 1'b1;
                end
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    // Starts a draw, records every plot; returns the first cycle done is seen.
    task automatic draw(input int cx, input int cy, input int r, input logic [2:0] col,
                        input int drop_at, output int done_cyc);
        @(negedge clk);
        centre_x = 8'(cx);
        centre_y = 7'(cy);
        radius   = 8'(r);
        colour   = col;
        start    = 1'b1;
        plot_cyc.delete();
        plot_xy.delete();
        dut_set.delete();
        bad_colour = 0;
        done_cyc   = -1;
        @(posedge clk);
        for (int cyc = 1; cyc <= MAX_CYC && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (vga_plot === 1'b1) begin
                plot_cyc.push_back(cyc);
                plot_xy.push_back(int'(vga_x) * 256 + int'(vga_y));
                dut_set[int'(vga_x) * 256 + int'(vga_y)] = 1'b1;
                if (vga_colour !== col) bad_colour++;
            end
            if (done === 1'b1) done_cyc = cyc;
            if (cyc == 2) begin
                centre_x = ~centre_x;
                centre_y = ~centre_y;
                radius   = ~radius;
                colour   = ~colour;
            end
            if (cyc == drop_at) start = 1'b0;
        end
        if (done_cyc < 0) check("done_timeout", 32'(done), 1);
    endtask

    task automatic compare_sets(input string tag);
        int miss;
        miss = 0;
        foreach (model_set[k]) if (!dut_set.exists(k)) miss++;
        check({tag, "_set_size"}, dut_set.size(), model_set.size());
        check({tag, "_set_miss"}, miss, 0);
    endtask

    vec_t vecs[5];
    int   r1_exp[8];

    initial begin
        int n_iter, n_plot, dc, exp_done, exp_plots, bad;

        vecs[0] = '{cx: 80,  cy: 60,  r: 0,   col: 3'b010, exp_done: 11, exp_plots: 8};
        vecs[1] = '{cx: 80,  cy: 60,  r: 1,   col: 3'b101, exp_done: 20, exp_plots: 16};
        vecs[2] = '{cx: 80,  cy: 60,  r: 40,  col: 3'b111, exp_done: -1, exp_plots: -1};
        vecs[3] = '{cx: 0,   cy: 0,   r: 10,  col: 3'b001, exp_done: 74, exp_plots: 18};
        vecs[4] = '{cx: 159, cy: 119, r: 255, col: 3'b110, exp_done: -1, exp_plots: 0};

        r1_exp = '{81*256+60, 80*256+61, 79*256+60, 80*256+61,
                   79*256+60, 80*256+59, 81*256+60, 80*256+59};

        rst_n = 1'b0;
        start = 1'b0;
        colour = 3'b111;
        centre_x = 8'd5;
        centre_y = 7'd5;
        radius = 8'd3;
        #12;
        check("reset_done",   32'(done),       0);
        check("reset_plot",   32'(vga_plot),   0);
        check("reset_x",      32'(vga_x),      0);
        check("reset_y",      32'(vga_y),      0);
        check("reset_colour", 32'(vga_colour), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            model(vecs[i].cx, vecs[i].cy, vecs[i].r, n_iter, n_plot);
            exp_done  = (vecs[i].exp_done  >= 0) ? vecs[i].exp_done  : 2 + 9 * n_iter;
            exp_plots = (vecs[i].exp_plots >= 0) ? vecs[i].exp_plots : n_plot;
            draw(vecs[i].cx, vecs[i].cy, vecs[i].r, vecs[i].col, 0, dc);
            check($sformatf("v%0d_done_cycle", i), dc, exp_done);
            check($sformatf("v%0d_plot_count", i), plot_cyc.size(), exp_plots);
            check($sformatf("v%0d_bad_colour", i), bad_colour, 0);
            compare_sets($sformatf("v%0d", i));
            bad = 0;
            repeat (4) begin
                @(negedge clk);
                if (done !== 1'b1 || vga_plot !== 1'b0) bad++;
            end
            check($sformatf("v%0d_hold_in_done", i), bad, 0);
            start = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_done_falls", i), 32'(done), 0);
        end

        // Radius 0: eight plots at the centre in cycles 2..9.
        draw(80, 60, 0, 3'b010, 0, dc);
        check("r0_count", plot_cyc.size(), 8);
        bad = 0;
        for (int k = 0; k < plot_cyc.size(); k++)
            if (plot_cyc[k] != 2 + k || plot_xy[k] != 80 * 256 + 60) bad++;
        check("r0_cycles_points", bad, 0);
        start = 1'b0;
        @(negedge clk);

        // Radius 1: first iteration in octant order.
        draw(80, 60, 1, 3'b101, 0, dc);
        bad = 0;
        for (int k = 0; k < 8; k++)
            if (k >= plot_xy.size() || plot_xy[k] != r1_exp[k] || plot_cyc[k] != 2 + k) bad++;
        check("r1_first_iter_order", bad, 0);
        start = 1'b0;
        @(negedge clk);

        // Clipping at the origin: the on-axis points survive.
        draw(0, 0, 10, 3'b001, 0, dc);
        check("clip_has_10_0", 32'(dut_set.exists(10 * 256 + 0)), 1);
        check("clip_has_0_10", 32'(dut_set.exists(0 * 256 + 10)), 1);
        start = 1'b0;
        @(negedge clk);

        // start dropped mid-draw: circle still completes, done lasts one cycle.
        draw(80, 60, 10, 3'b011, 5, dc);
        check("drop_done_cycle", dc, 74);
        check("drop_plot_count", plot_cyc.size(), 64);
        @(negedge clk);
        check("drop_done_one_cycle", 32'(done), 0);

        // Asynchronous reset in the middle of PLOT.
        @(negedge clk);
        centre_x = 8'd80;
        centre_y = 7'd60;
        radius   = 8'd10;
        colour   = 3'b111;
        start    = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        check("pre_reset_plotting", 32'(vga_plot), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", 32'({done, vga_plot, vga_x, vga_y, vga_colour}), 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'({done, vga_plot}), 0);
        draw(80, 60, 0, 3'b010, 0, dc);
        check("post_reset_redraw", dc, 11);
        start = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/circle.md
# circle

Midpoint (Bresenham) circle rasteriser for the 160x120 VGA frame. It sits between the screen-fill sequencer and `vga_adapter`, exactly where the Reuleaux drawer sits. On a start/done handshake it emits one candidate pixel per cycle on the adapter's `x`/`y`/`colour`/`plot` inputs. Pixels that fall off screen are suppressed by holding `vga_plot` low. The outline is not filled.

## Interface
Parameters:
- `SCREEN_W`, default 160, horizontal pixel count; valid x is 0..SCREEN_W-1.
- `SCREEN_H`, default 120, vertical pixel count; valid y is 0..SCREEN_H-1.

Ports:
- `clk` input 1: system clock (CLOCK_50 domain).
- `rst_n` input 1: reset, asynchronous and active-low.
- `colour` input 3: outline colour.
- `centre_x` input 8: centre x.
- `centre_y` input 7: centre y.
- `radius` input 8: radius in pixels, 0..255.
- `start` input 1: request; held high by the requester until `done` is seen.
- `done` output 1: drawing complete.
- `vga_x` output 8: pixel x.
- `vga_y` output 7: pixel y.
- `vga_colour` output 3: pixel colour.
- `vga_plot` output 1: write strobe to the adapter.

## Operation
- States: IDLE, INIT, PLOT, UPDATE, DONE.
- IDLE:
  - `start`=1 -> INIT.
- INIT:
  - Latch `colour`, `centre_x`, `centre_y` and `radius`. Input changes after this cycle are ignored.
  - Set `ox`=radius, `oy`=0, `crit`=1-radius, `oct`=0.
  - -> PLOT.
- PLOT:
  - One octant point per cycle, `oct` = 0..7, in this order:
    - 0: (cx+ox, cy+oy)
    - 1: (cx+oy, cy+ox)
    - 2: (cx-ox, cy+oy)
    - 3: (cx-oy, cy+ox)
    - 4: (cx-ox, cy-oy)
    - 5: (cx-oy, cy-ox)
    - 6: (cx+ox, cy-oy)
    - 7: (cx+oy, cy-ox)
  - After `oct`=7 -> UPDATE.
- UPDATE:
  - `oy`+=1.
  - If `crit`<=0: `crit` += 2*oy+1.
  - Else: `ox`-=1, then `crit` += 2*(oy-ox)+1.
  - Both formulas use the updated values of `oy` and `ox`.
  - If new `oy` <= new `ox`: `oct`=0 -> PLOT. Else -> DONE.
- DONE:
  - `done`=1.
  - `start`=0 -> IDLE.
  - `start` still 1 -> stay in DONE; no redraw.
- Arithmetic:
  - Point coordinates are 10-bit signed; `crit` is 11-bit signed. Neither can overflow for any input.
  - `vga_plot` = (state==PLOT) & 0<=px<SCREEN_W & 0<=py<SCREEN_H.
  - `vga_x`/`vga_y` are the low 8/7 bits of px/py when plotted, otherwise 0.
- `start` dropping during INIT, PLOT or UPDATE is ignored; the circle completes.
- Duplicate points (axes, diagonal, radius 0) are re-plotted and not filtered.

## Timing
- Reset (asynchronous, at any time, including mid-draw):
  - state=IDLE.
  - `done`=0, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0.
  - All internal registers cleared.
- Outputs are Moore: combinational from registered state, `oct`, offsets and latched inputs only. There is no combinational path from any input port.
- Cycle numbering: `start` is sampled high at edge 0.
  - INIT occupies cycle 1.
  - The first PLOT output is valid in cycle 2.
- Each iteration costs 9 cycles: 8 PLOT + 1 UPDATE.
- Total latency for N iterations: `done` rises at cycle 2+9N and stays high while `start`=1.
- `done` falls in the cycle after `start` is sampled low.
- A new `start` is accepted no earlier than the IDLE cycle that follows.

## Structure
- `circle_pkg` holds:
  - the state enum (`state_t`);
  - `SCREEN_W`/`SCREEN_H` defaults;
  - coordinate and `crit` width constants;
  - octant index constants.
- One combinational sub-module is natural: `circle_octant`.
  - Inputs: cx, cy, ox, oy, oct.
  - Outputs: px, py, on_screen.
  - It is reusable by the Reuleaux drawer for arc clipping.
- The FSM and datapath stay in `circle`.

## Test plan
- Radius 0 at (80,60), colour 3'b010:
  - 8 plots, all at (80,60), in cycles 2-9.
  - UPDATE in cycle 10; `done` high in cycle 11.
- Radius 1 at (80,60):
  - 2 iterations.
  - Iteration 1 plots (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59).
  - `done` at cycle 20.
- Radius 40 at (80,60):
  - Scoreboard the unique plotted set against a software midpoint model.
  - Every point is on screen; `done` at 2+9N with N taken from the model.
- Clipping, centre (0,0), radius 10:
  - No `vga_plot` for any point with a negative coordinate.
  - (10,0) and (0,10) are plotted.
  - Completion timing is unchanged.
- Clipping, centre (159,119), radius 255:
  - Every point is off screen, so `vga_plot` stays 0 throughout.
  - `done` still asserts.
- Handshake and reset:
  - Drop `start` mid-draw: the draw completes.
  - Hold `start` in DONE: no redraw.
  - Assert `rst_n`=0 mid-PLOT: all outputs go to 0 immediately and the FSM resumes from IDLE.
